// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: internal SoC reset-request generator.
// Raises a fixed-length, active-low reset request from a software request
// or a watchdog expiry, then enforces a hold-off window before the next one.
// Lives in the always-on POR domain: only rstn_i resets it, never its own
// request output.
module rst_req_ctrl #(
    parameter int RST_LEN   = 16,
    parameter int HOLDOFF   = 8,
    parameter int WDT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 testmode_i,
    input  logic                 sw_rst_req_i,
    input  logic                 wdt_en_i,
    input  logic                 wdt_kick_i,
    input  logic [WDT_WIDTH-1:0] wdt_timeout_i,
    input  logic                 cause_clr_i,
    output logic                 rst_req_no,
    output logic [1:0]           rst_cause_o,
    output logic                 busy_o,
    output logic [WDT_WIDTH-1:0] wdt_cnt_o
);

    // One shared down-counter times both ASSERT and HOLDOFF.
    localparam int MAX_LEN = (RST_LEN > HOLDOFF) ? RST_LEN : HOLDOFF;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] ASSERT_LOAD = CW'(RST_LEN - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLDOFF - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        dly_q, dly_d;
    logic [1:0]           cause_q, cause_d;
    logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
    logic                 req_n_q, req_n_d;
    logic                 busy_q, busy_d;

    logic wdt_run;
    logic wdt_at_limit;
    logic wdt_expire;
    logic trigger;

    // Watchdog: counts only while idle and enabled; kick beats expiry,
    // expiry restarts from zero, and the count saturates instead of wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        wdt_cnt_d    = '0;
        wdt_run      = (state_q == ST_IDLE) && wdt_en_i &&
                       (wdt_timeout_i != '0) && !testmode_i;
        wdt_at_limit = (wdt_cnt_q == wdt_timeout_i - WDT_WIDTH'(1));
        wdt_expire   = wdt_run && !wdt_kick_i && wdt_at_limit;
        if (wdt_run && !wdt_kick_i && !wdt_at_limit) begin
            wdt_cnt_d = (wdt_cnt_q == '1) ? wdt_cnt_q : wdt_cnt_q + WDT_WIDTH'(1);
        end
    end

    // Request sources; test mode suppresses both.
    assign trigger = !testmode_i && (sw_rst_req_i || wdt_expire);

    // FSM next state, delay counter, sticky cause and registered outputs.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        cause_d = cause_clr_i ? CAUSE_NONE : cause_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_ASSERT;
                    dly_d   = ASSERT_LOAD;
                    // Software wins a tie with the watchdog; a new cause
                    // overrides a same-cycle clear.
                    cause_d = sw_rst_req_i ? CAUSE_SW : CAUSE_WDT;
                end
            end
            ST_ASSERT: begin
                if (dly_q == '0) begin
                    state_d = ST_HOLDOFF;
                    dly_d   = HOLD_LOAD;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (dly_q == '0) begin
                    state_d = ST_IDLE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dly_d   = '0;
            end
        endcase

        // Test mode aborts any sequence and parks the FSM in IDLE.
        if (testmode_i) begin
            state_d = ST_IDLE;
            dly_d   = '0;
        end

        // Outputs are decoded from the next state so they leave a flop.
        req_n_d = (state_d != ST_ASSERT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers, cleared only by the pad/POR reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            cause_q   <= CAUSE_NONE;
            wdt_cnt_q <= '0;
            req_n_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            dly_q     <= dly_d;
            cause_q   <= cause_d;
            wdt_cnt_q <= wdt_cnt_d;
            req_n_q   <= req_n_d;
            busy_q    <= busy_d;
        end
    end

    assign rst_req_no  = req_n_q;
    assign rst_cause_o = cause_q;
    assign busy_o      = busy_q;
    assign wdt_cnt_o   = wdt_cnt_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb_rst_req_ctrl: directed, table-driven bench for rst_req_ctrl.
// Each table row holds inputs for a number of cycles, then checks outputs.
module tb_rst_req_ctrl;

    localparam int RST_LEN   = 16;
    localparam int HOLDOFF   = 8;
    localparam int WDT_WIDTH = 32;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 testmode_i;
    logic                 sw_rst_req_i;
    logic                 wdt_en_i;
    logic                 wdt_kick_i;
    logic [WDT_WIDTH-1:0] wdt_timeout_i;
    logic                 cause_clr_i;
    logic                 rst_req_no;
    logic [1:0]           rst_cause_o;
    logic                 busy_o;
    logic [WDT_WIDTH-1:0] wdt_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    rst_req_ctrl #(
        .RST_LEN  (RST_LEN),
        .HOLDOFF  (HOLDOFF),
        .WDT_WIDTH(WDT_WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .testmode_i   (testmode_i),
        .sw_rst_req_i (sw_rst_req_i),
        .wdt_en_i     (wdt_en_i),
        .wdt_kick_i   (wdt_kick_i),
        .wdt_timeout_i(wdt_timeout_i),
        .cause_clr_i  (cause_clr_i),
        .rst_req_no   (rst_req_no),
        .rst_cause_o  (rst_cause_o),
        .busy_o       (busy_o),
        .wdt_cnt_o    (wdt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        sw;
        logic        en;
        logic        kick;
        logic [31:0] tmo;
        logic        tm;
        logic        clr;
        int          n;
        logic        exp_rq;
        logic        exp_busy;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic sw, input logic en,
                                input logic kick, input logic [31:0] tmo,
                                input logic tm, input logic clr, input int n,
                                input logic rq, input logic busy,
                                input logic [1:0] cause, input logic [31:0] cnt);
        vec_t v;
        v.name = name; v.sw = sw; v.en = en; v.kick = kick; v.tmo = tmo;
        v.tm = tm; v.clr = clr; v.n = n; v.exp_rq = rq; v.exp_busy = busy;
        v.exp_cause = cause; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and step away from the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(input string name, input logic rq, input logic busy,
                              input logic [1:0] cause, input logic [31:0] cnt);
        check({name, ".rst_req_no"}, 32'(rst_req_no), 32'(rq));
        check({name, ".busy"},       32'(busy_o),     32'(busy));
        check({name, ".cause"},      32'(rst_cause_o), 32'(cause));
        check({name, ".wdt_cnt"},    wdt_cnt_o,        cnt);
    endtask

    initial begin
        // sw en kick tmo tm clr n | rq busy cause cnt
        vecs.push_back(mk("por_idle",     0,0,0, 0,0,0,100, 1,0,2'd0, 0));
        // Software request sampled at edge N, second pulse at N+10 ignored.
        vecs.push_back(mk("sw_edge",      1,0,0, 0,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("sw_mid",       0,0,0, 0,0,0,  9, 0,1,2'd1, 0));
        vecs.push_back(mk("sw_second",    1,0,0, 0,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("sw_last_asrt", 0,0,0, 0,0,0,  5, 0,1,2'd1, 0));
        vecs.push_back(mk("sw_release",   0,0,0, 0,0,0,  1, 1,1,2'd1, 0));
        vecs.push_back(mk("sw_hold_end",  0,0,0, 0,0,0,  7, 1,1,2'd1, 0));
        vecs.push_back(mk("sw_idle",      0,0,0, 0,0,0,  1, 1,0,2'd1, 0));
        vecs.push_back(mk("sw_ignored",   0,0,0, 0,0,0, 10, 1,0,2'd1, 0));
        // Watchdog: count to 30, kick, then expire exactly 50 cycles later.
        vecs.push_back(mk("wdt_cnt30",    0,1,0,50,0,0, 30, 1,0,2'd1,30));
        vecs.push_back(mk("wdt_kick",     0,1,1,50,0,0,  1, 1,0,2'd1, 0));
        vecs.push_back(mk("wdt_cnt49",    0,1,0,50,0,0, 49, 1,0,2'd1,49));
        vecs.push_back(mk("wdt_expire",   0,1,0,50,0,0,  1, 0,1,2'd2, 0));
        vecs.push_back(mk("wdt_assert",   0,1,0,50,0,0, 15, 0,1,2'd2, 0));
        vecs.push_back(mk("wdt_release",  0,1,0,50,0,0,  1, 1,1,2'd2, 0));
        vecs.push_back(mk("wdt_hold",     0,1,0,50,0,0,  8, 1,0,2'd2, 0));
        vecs.push_back(mk("wdt_restart",  0,1,0,50,0,0,  1, 1,0,2'd2, 1));
        vecs.push_back(mk("cause_clr",    0,0,0,50,0,1,  1, 1,0,2'd0, 0));
        // Software and expiry on the same edge: one 16-cycle ASSERT, cause sw.
        vecs.push_back(mk("sim_cnt49",    0,1,0,50,0,0, 49, 1,0,2'd0,49));
        vecs.push_back(mk("sim_both",     1,1,0,50,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("sim_len",      0,0,0,50,0,0, 15, 0,1,2'd1, 0));
        vecs.push_back(mk("sim_end",      0,0,0,50,0,0,  1, 1,1,2'd1, 0));
        vecs.push_back(mk("sim_idle",     0,0,0,50,0,0,  8, 1,0,2'd1, 0));
        // Clear together with a new watchdog cause: the new cause wins.
        vecs.push_back(mk("clrnew_cnt2",  0,1,0, 3,0,0,  2, 1,0,2'd1, 2));
        vecs.push_back(mk("clrnew_edge",  0,1,0, 3,0,1,  1, 0,1,2'd2, 0));
        vecs.push_back(mk("clrnew_done",  0,0,0, 3,0,0, 24, 1,0,2'd2, 0));
        // Test mode aborts ASSERT and blocks both request sources.
        vecs.push_back(mk("tm_start",     1,0,0, 3,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("tm_asrt",      0,0,0, 3,0,0,  4, 0,1,2'd1, 0));
        vecs.push_back(mk("tm_abort",     0,0,0, 3,1,0,  1, 1,0,2'd1, 0));
        vecs.push_back(mk("tm_block",     1,1,0, 3,1,0, 10, 1,0,2'd1, 0));
        vecs.push_back(mk("tm_exit",      0,0,0, 3,0,0,  2, 1,0,2'd1, 0));
        // Level request held through HOLDOFF retriggers one cycle after idle.
        vecs.push_back(mk("lvl_clr",      0,0,0, 0,0,1,  1, 1,0,2'd0, 0));
        vecs.push_back(mk("lvl_first",    1,0,0, 0,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("lvl_hold",     1,0,0, 0,0,0, 23, 1,1,2'd1, 0));
        vecs.push_back(mk("lvl_idle",     1,0,0, 0,0,0,  1, 1,0,2'd1, 0));
        vecs.push_back(mk("lvl_retrig",   1,0,0, 0,0,0,  1, 0,1,2'd1, 0));
        vecs.push_back(mk("lvl_drain",    0,0,0, 0,0,0, 24, 1,0,2'd1, 0));

        rstn_i        = 1'b0;
        testmode_i    = 1'b0;
        sw_rst_req_i  = 1'b0;
        wdt_en_i      = 1'b0;
        wdt_kick_i    = 1'b0;
        wdt_timeout_i = '0;
        cause_clr_i   = 1'b0;

        repeat (5) tick();
        check_outs("por", 1'b1, 1'b0, 2'd0, 32'd0);
        rstn_i = 1'b1;

        foreach (vecs[i]) begin
            sw_rst_req_i  = vecs[i].sw;
            wdt_en_i      = vecs[i].en;
            wdt_kick_i    = vecs[i].kick;
            wdt_timeout_i = vecs[i].tmo;
            testmode_i    = vecs[i].tm;
            cause_clr_i   = vecs[i].clr;
            repeat (vecs[i].n) tick();
            check_outs(vecs[i].name, vecs[i].exp_rq, vecs[i].exp_busy,
                       vecs[i].exp_cause, vecs[i].exp_cnt);
        end

        // Pad reset mid-ASSERT releases the request without a clock edge.
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        repeat (3) tick();
        check("async.pre_low", 32'(rst_req_no), 32'd0);
        #2 rstn_i = 1'b0;
        #1;
        check_outs("async", 1'b1, 1'b0, 2'd0, 32'd0);
        tick();
        rstn_i = 1'b1;
        tick();
        check_outs("async.after", 1'b1, 1'b0, 2'd0, 32'd0);

        // Watchdog enabled with no kicks: count equals k after k edges.
        wdt_timeout_i = 32'd100;
        wdt_en_i      = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("wdt_step%0d", k), wdt_cnt_o, 32'(k));
        end
        wdt_en_i = 1'b0;
        tick();
        check("wdt_disable_clr", wdt_cnt_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rst_req_ctrl.md
# rst_req_ctrl

Reset-request controller that drives the SoC reset input from inside the chip. The reset synchronizer consumes pad reset and produces the SoC reset; this block generates the SoC reset instead, from a software request or a watchdog expiry. It lives in the always-on pad/POR domain, so its own request never resets it. rst_req_no is ANDed with the pad reset before the SoC reset synchronizer.

## Interface
Parameters:
- RST_LEN, 16: cycles rst_req_no is held low per request (≥1)
- HOLDOFF, 8: cycles after release during which new requests are ignored (≥1)
- WDT_WIDTH, 32: watchdog counter/timeout width

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  pad/POR reset, asynchronous, active-low; this reset only, never rst_req_no
- testmode_i  in  1  scan/test mode; suppresses all internal reset requests
- sw_rst_req_i  in  1  software reset request, level; sampled in IDLE
- wdt_en_i  in  1  watchdog enable
- wdt_kick_i  in  1  watchdog service pulse
- wdt_timeout_i  in  WDT_WIDTH  expiry threshold in cycles; 0 disables the watchdog
- cause_clr_i  in  1  clears rst_cause_o
- rst_req_no  out  1  registered active-low reset request to the SoC reset synchronizer
- rst_cause_o  out  2  sticky cause of the last request: 00 none, 01 software, 10 watchdog
- busy_o  out  1  high in ASSERT and HOLDOFF
- wdt_cnt_o  out  WDT_WIDTH  current watchdog count

## Operation
- FSM states:
  - IDLE: accepts requests; rst_req_no=1.
  - ASSERT: rst_req_no=0.
  - HOLDOFF: rst_req_no=1; requests ignored.
- One down-counter (width ≥ clog2(max(RST_LEN,HOLDOFF)+1)) is loaded on each state entry.
- IDLE -> ASSERT when any of these holds and testmode_i=0:
  - sw_rst_req_i=1
  - watchdog expiry
- ASSERT -> HOLDOFF after exactly RST_LEN cycles in ASSERT.
- HOLDOFF -> IDLE after exactly HOLDOFF cycles.
- Watchdog counts only in IDLE with wdt_en_i=1, wdt_timeout_i≠0 and testmode_i=0. Per cycle, priority order:
  - kick: count <= 0
  - count == wdt_timeout_i-1: expiry, count <= 0
  - otherwise: count+1
- Counter wraps never; reaching wdt_timeout_i-1 always expires.
- Counter is cleared whenever:
  - wdt_en_i=0
  - wdt_timeout_i=0
  - testmode_i=1
  - the FSM is in ASSERT or HOLDOFF
- Lowering wdt_timeout_i below the current count: expiry fires only when count reaches the new value-1; the count never wraps. Software is responsible for kicking before changing the timeout.
- Cause recording:
  - sw and expiry in the same cycle: software wins, cause=01.
  - rst_cause_o is written on entry to ASSERT and holds until cause_clr_i.
  - cause_clr_i and a new cause in the same cycle: the new cause wins.
- Requests arriving in ASSERT or HOLDOFF are dropped, not queued.
- A level sw_rst_req_i still high after HOLDOFF triggers a new request.
- testmode_i=1 forces:
  - FSM -> IDLE next cycle from any state, aborting ASSERT
  - rst_req_no=1, busy_o=0 from that edge
  - rst_cause_o unchanged

## Timing
- Reset values (rstn_i=0, asynchronous):
  - rst_req_no=1
  - rst_cause_o=00
  - busy_o=0
  - wdt_cnt_o=0
  - FSM=IDLE
- All outputs registered; no combinational input→output path.
- Request latency: trigger sampled at edge N → rst_req_no=0 and busy_o=1 after edge N (cycles N+1..N+RST_LEN).
- rst_req_no returns to 1 at cycle N+RST_LEN+1.
- busy_o falls at cycle N+RST_LEN+HOLDOFF+1; a new request is accepted at that edge.
- Watchdog: with wdt_en_i rising at edge 0 and no kicks, wdt_cnt_o=k after edge k. Expiry is sampled at the edge with count=T-1, so rst_req_no falls at cycle T.
- rstn_i asserted mid-ASSERT: rst_req_no=1 immediately (asynchronous); state lost.

## Test plan
- POR and idle: rstn_i low for 5 cycles, then high, all request inputs 0 → rst_req_no=1, cause=00, busy_o=0 for 100 cycles.
- Software reset: RST_LEN=16, HOLDOFF=8, sw_rst_req_i pulsed at edge 10 → rst_req_no=0 for cycles 11..26, busy_o=1 for cycles 11..34, cause=01. A second pulse at cycle 20 is ignored.
- Watchdog expiry and kick:
  - wdt_en_i=1, timeout=50, kick at count 30 → count returns to 0.
  - No further kicks → rst_req_no falls exactly 50 cycles after the kick, cause=10, wdt_cnt_o=0 during ASSERT.
- Simultaneous sources: sw request and expiry at the same edge → single ASSERT of 16 cycles, cause=01.
- cause_clr_i together with a new request at the same edge → cause is the new value, not 00.
- Test mode:
  - testmode_i raised at ASSERT cycle 5 → rst_req_no=1 and busy_o=0 next cycle.
  - sw request and an expiring watchdog (timeout=3) under testmode → rst_req_no stays 1 and wdt_cnt_o stays 0.
